mem_refill_ctrl: RTL
====================

MEM_REFILL_CTRL -- requirements
Module: mem_refill_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, word width.
REQ-002 SHALL have parameter BLOCK_SIZE, default 4, words per block; only 4 supported.
REQ-003 SHALL have parameter MEM_AW, default 16, word-address bits of backing store (2**MEM_AW words).
REQ-004 SHALL have port clk, input, 1, sole clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req_valid, input, 1, cache requests service (refill and/or write-back).
REQ-007 SHALL have port req_ready, output, 1, high only when the controller accepts a request.
REQ-008 SHALL have port refill_en, input, 1, the request includes a block refill.
REQ-009 SHALL have port refill_addr, input, DATA_WIDTH, byte address of the missing block.
REQ-010 SHALL have port write_back_valid, input, 1, the request includes a dirty-block write-back.
REQ-011 SHALL have port write_back_addr, input, DATA_WIDTH, block byte address of the victim.
REQ-012 SHALL have port write_back_data, input, 4*DATA_WIDTH, victim block; word i in bits [32i+31:32i].
REQ-013 SHALL have port fetch_data, output, 4*DATA_WIDTH, refilled block, same word packing.
REQ-014 SHALL have port fetch_enable, output, 1, one-cycle pulse: fetch_data valid, cache installs it.
REQ-015 SHALL have port busy, output, 1, high in every non-IDLE state (pipeline stall).

Function
REQ-016 SHALL accept a request on a rising edge where req_valid && req_ready; inputs captured then, later changes ignored.
REQ-017 SHALL implement FSM IDLE -> WB (if write_back_valid) -> FILL (if refill_en) -> RESP -> IDLE; absent phases skipped.
REQ-018 SHALL drive req_ready = 1 only in IDLE; requests in other states ignored, requester holds req_valid.
REQ-019 SHALL treat address bits [3:0] as ignored (block aligned) and bits above MEM_AW+1 as ignored (wrap).
REQ-020 SHALL in WB write one word per cycle, word i to block base + 4i, i = 0..3, via 2-bit counter, 4 cycles.
REQ-021 SHALL in FILL read one word per cycle (asynchronous read), word i into fetch_data slot i, 4 cycles.
REQ-022 SHALL perform WB before FILL so a refill of the same block returns the written-back data.
REQ-023 SHALL in RESP assert fetch_enable for exactly one cycle, fetch_data stable that cycle and held after.
REQ-024 SHALL with refill only: accept edge k, fetch_enable high in cycle k+5; with write-back too, k+9.
REQ-025 SHALL with write-back only: return to IDLE after WB with no fetch_enable pulse.
REQ-026 SHALL treat req_valid with neither refill_en nor write_back_valid as a no-op; stays IDLE.
REQ-027 SHALL reset counter to 0 on every phase entry; counter wraps 3 -> 0 at phase exit.

Reset
REQ-028 SHALL on rst force state IDLE, counter 0, fetch_enable 0, busy 0, req_ready 1 next cycle, fetch_data 0.
REQ-029 SHALL on rst mid-operation abandon the transaction; words already written stay; memory never cleared by reset.

Configuration
REQ-030 SHALL support macro REFILL_FORWARD_EN: when defined and write-back and refill block addresses are equal, FILL is skipped and fetch_data = write_back_data, fetch_enable at k+5 after WB.
REQ-031 SHALL without REFILL_FORWARD_EN always perform FILL from memory; data identical, latency per REQ-024.

Structure
REQ-032 SHALL place state enum (IDLE, WB, FILL, RESP), BLOCK_BYTES = 16 and WORD_OFS_BITS = 2 in package mem_ctrl_pkg.
REQ-033 SHALL instantiate sub-module main_mem: word array, synchronous write, asynchronous read, optional $readmemh init.

Verification
REQ-034 SHALL cover: mem preloaded word j = j; refill 0x20 -> fetch_enable at k+5, fetch_data = {0xB,0xA,0x9,0x8}.
REQ-035 SHALL cover: write-back 0x40 data {4,3,2,1} plus refill 0x80 -> pulse at k+9, later refill 0x40 returns {4,3,2,1}.
REQ-036 SHALL cover: write-back and refill both 0x60, data {D,C,B,A} -> fetch_data {D,C,B,A}; pulse k+5 after WB with macro, k+9 without.
REQ-037 SHALL cover: req_valid held through busy with new addr -> ignored until IDLE, req_ready low meanwhile.
REQ-038 SHALL cover: rst asserted during FILL cycle 2 -> IDLE next cycle, no fetch_enable, req_ready 1.
REQ-039 SHALL cover: refill 0x2C (unaligned) -> same data as 0x20; address 0x40000 wraps to 0x0 with MEM_AW = 16.

Source files
------------

// File: rtl/mem_ctrl_pkg.sv
// Shared FSM state encoding and block geometry for the refill controller.
package mem_ctrl_pkg;
  typedef enum logic [1:0] {
    IDLE,
    WB,
    FILL,
    RESP
  } state_t;

  localparam int BLOCK_BYTES = 16;
  localparam int WORD_OFS_BITS = 2;
  localparam int BLOCK_OFS_BITS = $clog2(BLOCK_BYTES);
endpackage

// File: rtl/main_mem.sv
// Backing word store: synchronous write, asynchronous read.
module main_mem #(
  parameter int DATA_WIDTH = 32,
  parameter int MEM_AW = 16
) (
  input  logic                  clk,
  input  logic                  we,
  input  logic [MEM_AW-1:0]     addr,
  input  logic [DATA_WIDTH-1:0] wdata,
  output logic [DATA_WIDTH-1:0] rdata
);
  logic [DATA_WIDTH-1:0] mem [2**MEM_AW];

  always_ff @(posedge clk) begin
    if (we) mem[addr] <= wdata;
  end

  assign rdata = mem[addr];
endmodule

// File: rtl/mem_refill_ctrl.sv
// Block refill / write-back controller in front of main_mem.
// Define REFILL_FORWARD_EN to forward write-back data to a same-block refill.
module mem_refill_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int DATA_WIDTH = 32,
  parameter int BLOCK_SIZE = 4,
  parameter int MEM_AW = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    refill_en,
  input  logic [DATA_WIDTH-1:0]   refill_addr,
  input  logic                    write_back_valid,
  input  logic [DATA_WIDTH-1:0]   write_back_addr,
  input  logic [4*DATA_WIDTH-1:0] write_back_data,
  output logic [4*DATA_WIDTH-1:0] fetch_data,
  output logic                    fetch_enable,
  output logic                    busy
);
  localparam int BW = MEM_AW - WORD_OFS_BITS;

  state_t                  state;
  logic [1:0]              cnt;
  logic                    do_fill;
  logic [BW-1:0]           wb_blk;
  logic [BW-1:0]           rf_blk;
  logic [4*DATA_WIDTH-1:0] wb_buf;
  logic [BW-1:0]           in_wb_blk;
  logic [BW-1:0]           in_rf_blk;
  logic                    mem_we;
  logic [MEM_AW-1:0]       mem_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [DATA_WIDTH-1:0]   rd_data;
  logic                    unused_addr_bits;

  assign in_wb_blk = write_back_addr[MEM_AW+1:BLOCK_OFS_BITS];
  assign in_rf_blk = refill_addr[MEM_AW+1:BLOCK_OFS_BITS];

  // Offset bits and bits above the store size are intentionally dropped.
  assign unused_addr_bits = ^{
    write_back_addr[BLOCK_OFS_BITS-1:0],
    write_back_addr[DATA_WIDTH-1:MEM_AW+2],
    refill_addr[BLOCK_OFS_BITS-1:0],
    refill_addr[DATA_WIDTH-1:MEM_AW+2]
  };

  assign mem_we = (state == WB) && !rst;
  assign mem_addr = {(state == WB) ? wb_blk : rf_blk, cnt};
  assign wr_data = wb_buf[DATA_WIDTH*cnt +: DATA_WIDTH];

  main_mem #(
    .DATA_WIDTH(DATA_WIDTH),
    .MEM_AW    (MEM_AW)
  ) u_mem (
    .clk  (clk),
    .we   (mem_we),
    .addr (mem_addr),
    .wdata(wr_data),
    .rdata(rd_data)
  );

`ifdef REFILL_FORWARD_EN
  logic fwd_hit;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt <= 2'd0;
      fetch_enable <= 1'b0;
      busy <= 1'b0;
      req_ready <= 1'b1;
      fetch_data <= '0;
    end else begin
      fetch_enable <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid && req_ready) begin
            cnt <= 2'd0;
            wb_blk <= in_wb_blk;
            rf_blk <= in_rf_blk;
            wb_buf <= write_back_data;
            do_fill <= refill_en;
`ifdef REFILL_FORWARD_EN
            fwd_hit <= write_back_valid && refill_en
                       && (in_wb_blk == in_rf_blk);
`endif
            if (write_back_valid) begin
              state <= WB;
              busy <= 1'b1;
              req_ready <= 1'b0;
            end else if (refill_en) begin
              state <= FILL;
              busy <= 1'b1;
              req_ready <= 1'b0;
            end
          end
        end
        WB: begin
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) begin
`ifdef REFILL_FORWARD_EN
            if (do_fill && fwd_hit) begin
              fetch_data <= wb_buf;
              state <= RESP;
            end else
`endif
            if (do_fill) begin
              state <= FILL;
            end else begin
              state <= IDLE;
              busy <= 1'b0;
              req_ready <= 1'b1;
            end
          end
        end
        FILL: begin
          fetch_data[DATA_WIDTH*cnt +: DATA_WIDTH] <= rd_data;
          cnt <= cnt + 2'd1;
          if (cnt == 2'd3) state <= RESP;
        end
        RESP: begin
          fetch_enable <= 1'b1;
          state <= IDLE;
          busy <= 1'b0;
          req_ready <= 1'b1;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
